mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between two requesters: instruction fetch (IF, read-only word) and load/store unit (LS, read/write with byte mask).
- Sits between the core's fetch and LSU (downstream of the byte-mask/alignment controller) and the memory macro.
- Sequences each access through a small FSM with a configurable wait-state counter.
- Returns the raw memory word to the requester over a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of requester byte addresses.
- WAIT_CYCLES, 0, extra cycles mem_read/mem_write are held beyond the first (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted
- if_req_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  fetch response valid
- if_rsp_data  out  32  fetch word
- if_rsp_ready  in  1  fetch response consumed
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_req_addr  in  ADDR_W  LSU byte address
- ls_req_write  in  1  1=store, 0=load
- ls_req_wdata  in  32  store data, already lane-aligned
- ls_req_mask  in  4  byte enables
- ls_rsp_valid  out  1  LSU response valid (load data or store ack)
- ls_rsp_data  out  32  load word; 0 for stores
- ls_rsp_ready  in  1  LSU response consumed
- mem_addr  out  ADDR_W-2  word address = req_addr[ADDR_W-1:2]
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_mask  out  4  byte write enables
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after the last mem_read cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: FSM=IDLE; all *_ready, *_rsp_valid, mem_read, mem_write, busy = 0; mem_mask=0; rsp data registers=0; wait counter=0.
- Reset mid-operation: any in-flight access is abandoned and its response discarded. No memory strobe is asserted in the cycle after rst.
- IDLE:
  - *_req_ready is combinational and is 1 only for the winner; it is never 1 for both.
  - Fixed priority: LS wins over IF.
  - On handshake (valid & ready) the arbiter latches addr, write, wdata, mask and grant id, then goes to ACCESS.
  - No valid: stays in IDLE.
- ACCESS (1+WAIT_CYCLES cycles):
  - Drives mem_addr from the latched request.
  - Load or fetch: mem_read=1, mem_mask=0.
  - Store: mem_write=1, mem_mask=latched mask, mem_wdata=latched wdata.
  - Store with mask 4'b0000: mem_write stays 0 for the whole access; the request still completes with an ack (upstream exception path).
  - The counter loads WAIT_CYCLES on entry and decrements each cycle; go to DATA when it reaches 0.
  - Fetch addresses are word-aligned by truncation; low 2 bits are ignored.
- DATA (1 cycle):
  - All mem strobes are 0.
  - Register mem_rdata into the granted requester's rsp_data; stores register 0.
  - Go to RESP.
- RESP:
  - Only the granted requester's rsp_valid=1; rsp_data is held stable.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - rsp_valid stays high indefinitely while rsp_ready=0.
- Latency: request accepted in cycle T → rsp_valid from cycle T+3+WAIT_CYCLES. The next request can be accepted no earlier than the cycle after rsp_ready.
- Simultaneous IF and LS valid in IDLE: only the winner gets ready. The loser must hold valid and address stable until it is granted.
- mem outputs other than strobes and mask are don't-care outside ACCESS but are driven from registers (no X).
- busy = (state != IDLE).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register (reset value = IF) is updated on every grant. On contention the requester not granted last wins, so the first contention after reset goes to LS, the next to IF, and so on. With a single requester valid, it wins regardless of last_grant.
- Undefined: fixed LS-over-IF priority; no last_grant register is instantiated.

Test Plan:
- Reset, then single IF fetch at addr 0x0000_0010, WAIT_CYCLES=0, memory word 0xDEADBEEF → mem_addr=0x4 and mem_read=1 for 1 cycle; if_rsp_valid rises 3 cycles after the accept with if_rsp_data=0xDEADBEEF.
- LS store addr 0x8, wdata 0x0000AB00, mask 0010 → mem_write=1 and mem_mask=0010 for 1 cycle; the word at 0x2 updates byte1 only; ls_rsp_valid with data 0.
- IF and LS valid in the same cycle, repeated 3 times → fixed build: LS granted every time while IF stalls. With ARB_ROUND_ROBIN_EN: grants LS, IF, LS.
- WAIT_CYCLES=3 load, then hold ls_rsp_ready=0 for 5 cycles → mem_read high exactly 4 cycles; ls_rsp_valid/data held stable 5 cycles; IDLE one cycle after ready.
- Store with mask 0000 → mem_write never asserted; ls_rsp_valid still returned after 3 cycles.
- rst asserted during ACCESS of a load → next cycle state IDLE, mem_read=0, no rsp_valid ever issued for that load.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LS) arbiter sharing one single-port synchronous memory.
// Define ARB_ROUND_ROBIN_EN to replace fixed LS-over-IF priority with round-robin on contention.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [ADDR_W-1:0] if_req_addr_i,
  output logic              if_rsp_valid_o,
  output logic [31:0]       if_rsp_data_o,
  input  logic              if_rsp_ready_i,
  input  logic              ls_req_valid_i,
  output logic              ls_req_ready_o,
  input  logic [ADDR_W-1:0] ls_req_addr_i,
  input  logic              ls_req_write_i,
  input  logic [31:0]       ls_req_wdata_i,
  input  logic [3:0]        ls_req_mask_i,
  output logic              ls_rsp_valid_o,
  output logic [31:0]       ls_rsp_data_o,
  input  logic              ls_rsp_ready_i,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [3:0]        mem_mask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StData, StResp} state_e;

  localparam logic [3:0] WaitInit = WAIT_CYCLES[3:0];

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              grant_ls_q, grant_ls_d;
  logic [3:0]        wait_q, wait_d;
  logic [31:0]       if_rsp_q, if_rsp_d;
  logic [31:0]       ls_rsp_q, ls_rsp_d;

  logic ls_win, if_win, idle;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr_i[1:0], ls_req_addr_i[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_ls_q;
  // On contention the requester not granted last time wins.
  assign ls_win = ls_req_valid_i & (~if_req_valid_i | ~last_grant_ls_q);
`else
  assign ls_win = ls_req_valid_i;
`endif
  assign if_win = if_req_valid_i & ~ls_win;

  always_comb begin
    idle           = (state_q == StIdle) & ~rst_i;
    ls_req_ready_o = idle & ls_win;
    if_req_ready_o = idle & if_win;
    if_rsp_valid_o = (state_q == StResp) & ~grant_ls_q;
    ls_rsp_valid_o = (state_q == StResp) & grant_ls_q;
    if_rsp_data_o  = if_rsp_q;
    ls_rsp_data_o  = ls_rsp_q;
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    mem_read_o     = (state_q == StAccess) & ~write_q;
    mem_write_o    = (state_q == StAccess) & write_q & (|mask_q);
    mem_mask_o     = ((state_q == StAccess) && write_q) ? mask_q : 4'b0000;
    busy_o         = (state_q != StIdle);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    grant_ls_d = grant_ls_q;
    wait_d     = wait_q;
    if_rsp_d   = if_rsp_q;
    ls_rsp_d   = ls_rsp_q;
    unique case (state_q)
      StIdle: begin
        if (ls_win || if_win) begin
          grant_ls_d = ls_win;
          addr_d     = ls_win ? ls_req_addr_i[ADDR_W-1:2] : if_req_addr_i[ADDR_W-1:2];
          write_d    = ls_win & ls_req_write_i;
          wdata_d    = ls_win ? ls_req_wdata_i : 32'h0;
          mask_d     = ls_win ? ls_req_mask_i : 4'h0;
          wait_d     = WaitInit;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (wait_q == 4'd0) begin
          state_d = StData;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StData: begin
        if (grant_ls_q) begin
          ls_rsp_d = write_q ? 32'h0 : mem_rdata_i;
        end else begin
          if_rsp_d = mem_rdata_i;
        end
        state_d = StResp;
      end
      StResp: begin
        if (grant_ls_q ? ls_rsp_ready_i : if_rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= 32'h0;
      mask_q     <= 4'h0;
      grant_ls_q <= 1'b0;
      wait_q     <= 4'd0;
      if_rsp_q   <= 32'h0;
      ls_rsp_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      grant_ls_q <= grant_ls_d;
      wait_q     <= wait_d;
      if_rsp_q   <= if_rsp_d;
      ls_rsp_q   <= ls_rsp_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_ls_q <= 1'b0;
    end else if (ls_req_ready_o || if_req_ready_o) begin
      last_grant_ls_q <= ls_req_ready_o;
    end
  end
`endif

endmodule
